read_packet_from_mem: RTL

READ_PACKET_FROM_MEM -- requirements
Module: read_packet_from_mem

---
 rtl/copy_mem_pkg.sv | 15 +
 rtl/tx_skid_buffer.sv | 67 ++++++
 rtl/read_packet_from_mem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/copy_mem_pkg.sv
// copy_mem_pkg
//   Shared definitions for the ring-buffer packet reader: the FSM state
//   encoding and the default inter-frame gap length.
package copy_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Idle cycles inserted after every packet unless overridden.
  localparam int unsigned IFG_DEFAULT = 12;

endpackage : copy_mem_pkg

// File: rtl/tx_skid_buffer.sv
// tx_skid_buffer
//   Two-entry skid stage between the ring-buffer read port and the transmit
//   interface. The head entry drives the outputs directly from registers, so
//   the presented beat stays stable while the downstream stalls.
//
//   iclk, i_rst   clock, asynchronous active-low reset
//   push_i        store push_data_i (returned read data) this cycle
//   push_data_i   packed beat {data, sop, eop}
//   pop_i         head beat accepted downstream (valid_o & ready)
//   valid_o       head entry holds a beat
//   data_o        head beat {data, sop, eop}
//   count_o       number of occupied entries (0..2)
module tx_skid_buffer #(
  parameter int unsigned pWIDTH = 10
) (
  input  logic              iclk,
  input  logic              i_rst,
  input  logic              push_i,
  input  logic [pWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [pWIDTH-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [pWIDTH-1:0] head_q, tail_q;
  logic              head_vld_q, tail_vld_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      // NOTE: the data registers are reset as well (only two entries), so a
      // reset can never leave stale sop/eop bits behind.
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else if (pop_i) begin
      if (tail_vld_q) begin
        head_q <= tail_q;
        if (push_i) begin
          tail_q <= push_data_i;
        end else begin
          tail_vld_q <= 1'b0;
        end
      end else if (push_i) begin
        head_q <= push_data_i;
      end else begin
        head_vld_q <= 1'b0;
      end
    end else if (push_i) begin
      if (!head_vld_q) begin
        head_q     <= push_data_i;
        head_vld_q <= 1'b1;
      end else begin
        tail_q     <= push_data_i;
        tail_vld_q <= 1'b1;
      end
    end
  end

  assign valid_o = head_vld_q;
  assign data_o  = head_q;
  assign count_o = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

endmodule : tx_skid_buffer

// File: rtl/read_packet_from_mem.sv
// read_packet_from_mem
//   Pops packet lengths from a first-word-fall-through length FIFO, reads the
//   packet bytes out of a ring buffer (one-cycle read latency) and streams them
//   with sop/eop framing, followed by a fixed inter-frame gap.
//
//   iclk, i_rst      clock, asynchronous active-low reset
//   ilen_empty       length FIFO empty
//   ilen_data        head of length FIFO (valid while ilen_empty = 0)
//   olen_rd          one-cycle pop strobe to the length FIFO
//   orb_raddr        ring-buffer read address (registered read pointer)
//   irb_rdata        ring-buffer data for last cycle's address
//   itx_ready        downstream accepts a beat
//   otx_d/dv/sop/eop transmit beat and framing
//   orb_rptr         oldest unconsumed byte, for the writer's free space
//   odrop            pulse when a zero-length entry is discarded
//   obusy            FSM outside IDLE
module read_packet_from_mem
  import copy_mem_pkg::*;
#(
  parameter int unsigned pFIFO_SIZE = 16,
  parameter int unsigned pRB_WIDHT  = 14,
  parameter int unsigned pMEM_WIDTH = 8,
  parameter int unsigned pIFG       = IFG_DEFAULT
) (
  input  logic                  iclk,
  input  logic                  i_rst,
  input  logic                  ilen_empty,
  input  logic [pFIFO_SIZE-1:0] ilen_data,
  output logic                  olen_rd,
  output logic [pRB_WIDHT-1:0]  orb_raddr,
  input  logic [pMEM_WIDTH-1:0] irb_rdata,
  input  logic                  itx_ready,
  output logic [pMEM_WIDTH-1:0] otx_d,
  output logic                  otx_dv,
  output logic                  otx_sop,
  output logic                  otx_eop,
  output logic [pRB_WIDHT-1:0]  orb_rptr,
  output logic                  odrop,
  output logic                  obusy
);

  localparam int unsigned GAP_W  = (pIFG > 1) ? $clog2(pIFG + 1) : 1;
  localparam int unsigned BEAT_W = pMEM_WIDTH + 2;

  state_e                state_q;
  logic                  olen_rd_q, odrop_q;
  logic [pRB_WIDHT-1:0]  rd_ptr_q, rptr_q;
  logic [pFIFO_SIZE-1:0] reads_left_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  // Framing of the read currently in flight (data returns next cycle).
  logic                  rd_pend_q, pend_sop_q, pend_eop_q;

  logic                  skid_vld;
  logic [BEAT_W-1:0]     skid_data;
  logic [1:0]            skid_cnt;

  logic beat_acc, start_pkt, want_rd, has_room, rd_en, rd_sop, rd_eop;

  assign beat_acc  = skid_vld & itx_ready;
  // The first read of a packet is issued in the pop cycle itself, which is
  // what puts the first beat on the output two cycles after olen_rd.
  assign start_pkt = (state_q == ST_IDLE) && olen_rd_q && (ilen_data != '0);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    want_rd  = start_pkt || ((state_q == ST_STREAM) && (reads_left_q != '0));
    // Credit check: entries held + read in flight - beat leaving now must
    // leave a free slot for the byte this read returns.
    has_room = ({1'b0, skid_cnt} + {2'b0, rd_pend_q} - {2'b0, beat_acc}) < 3'd2;
    rd_en    = want_rd && has_room;
    rd_sop   = (state_q == ST_IDLE);
    rd_eop   = (state_q == ST_IDLE) ? (ilen_data == pFIFO_SIZE'(1))
                                    : (reads_left_q == pFIFO_SIZE'(1));
  end

  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      olen_rd_q    <= 1'b0;
      odrop_q      <= 1'b0;
      rd_ptr_q     <= '0;
      rptr_q       <= '0;
      reads_left_q <= '0;
      gap_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      pend_sop_q   <= 1'b0;
      pend_eop_q   <= 1'b0;
    end else begin
      olen_rd_q <= 1'b0;
      odrop_q   <= 1'b0;
      rd_pend_q <= rd_en;
      if (rd_en) begin
        rd_ptr_q   <= rd_ptr_q + pRB_WIDHT'(1);
        pend_sop_q <= rd_sop;
        pend_eop_q <= rd_eop;
      end
      if (beat_acc) begin
        rptr_q <= rptr_q + pRB_WIDHT'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (olen_rd_q) begin
            // ilen_data is still the popped entry during the strobe cycle.
            if (ilen_data == '0) begin
              odrop_q <= 1'b1;
            end else begin
              // The skid stage is empty here, so the first read always issues.
              reads_left_q <= ilen_data - pFIFO_SIZE'(1);
              state_q      <= ST_STREAM;
            end
          end else begin
            olen_rd_q <= !ilen_empty;
          end
        end
        ST_STREAM: begin
          if (rd_en) begin
            reads_left_q <= reads_left_q - pFIFO_SIZE'(1);
          end
          if (beat_acc && skid_data[0]) begin
            if (pIFG == 0) begin
              state_q   <= ST_IDLE;
              olen_rd_q <= !ilen_empty;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GAP_W'(pIFG);
            end
          end
        end
        ST_GAP: begin
          // The pop strobe is prepared here but lands in the first IDLE cycle.
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q   <= ST_IDLE;
            olen_rd_q <= !ilen_empty;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tx_skid_buffer #(
    .pWIDTH (BEAT_W)
  ) u_skid (
    .iclk        (iclk),
    .i_rst       (i_rst),
    .push_i      (rd_pend_q),
    .push_data_i ({irb_rdata, pend_sop_q, pend_eop_q}),
    .pop_i       (beat_acc),
    .valid_o     (skid_vld),
    .data_o      (skid_data),
    .count_o     (skid_cnt)
  );

  assign olen_rd   = olen_rd_q;
  assign odrop     = odrop_q;
  assign orb_raddr = rd_ptr_q;
  assign orb_rptr  = rptr_q;
  assign obusy     = (state_q != ST_IDLE);
  assign otx_dv    = skid_vld;
  assign otx_d     = skid_data[BEAT_W-1:2];
  assign otx_sop   = skid_vld & skid_data[1];
  assign otx_eop   = skid_vld & skid_data[0];

endmodule : read_packet_from_mem
